dct_master: RTL and testbench

- Avalon-style initiator that drives the avalon_dct responder on behalf of a host.
- The host fills a local sample buffer, sets size and Q format, then pulses start.
- The block issues the SETQ, START and DATA write sequence, then reads every result back, honouring the responder's done (wait) signal.
- Results land in a local result buffer that the host reads combinationally.
- Sits between the processor-side control logic and the DCT peripheral.

---
 rtl/dct_pkg.sv | 26 ++
 rtl/dct_master_if.sv | 21 ++
 rtl/dct_buffer.sv | 30 +++
 rtl/dct_master.sv | 211 +++++++++++++++++++++
 tb/tb_dct_master.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/dct_pkg.sv
// Shared constants, state encoding and helpers for the DCT initiator and its buffers.
package dct_pkg;

   localparam int MAX_SIZE_DEF = 32;
   localparam int NBITS_DEF    = 16;

   localparam logic [7:0] ADDR_START = 8'h0;
   localparam logic [7:0] ADDR_DATA  = 8'h1;
   localparam logic [7:0] ADDR_SETQ  = 8'h2;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_SETQ = 3'd1,
      S_SIZE = 3'd2,
      S_DATA = 3'd3,
      S_READ = 3'd4,
      S_DONE = 3'd5,
      S_FAIL = 3'd6
   } dct_master_state_t;

   // A transform needs at least two points and must fit in the local buffers.
   function automatic logic size_ok(input logic [7:0] sz, input int max_size);
      return (sz >= 8'd2) && (int'(sz) <= max_size);
   endfunction

endpackage

// File: rtl/dct_master_if.sv
// Avalon-style bus between the DCT initiator (master) and the avalon_dct responder (slave).
interface dct_master_if #(
   parameter int NBITS = 16
);
   logic [7:0]       m_address;
   logic             m_write;
   logic             m_read;
   logic [NBITS-1:0] m_writedata;
   logic [NBITS-1:0] m_readdata;
   logic             m_done;

   modport master (
      output m_address, m_write, m_read, m_writedata,
      input  m_readdata, m_done
   );

   modport slave (
      input  m_address, m_write, m_read, m_writedata,
      output m_readdata, m_done
   );
endinterface

// File: rtl/dct_buffer.sv
// DEPTH x WIDTH register array: one synchronous write port, one combinational read port.
module dct_buffer #(
   parameter int DEPTH = 32,
   parameter int WIDTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dct_master.sv
// Drives the avalon_dct responder: SETQ, START(size) and DATA writes, then reads every result
// back into a host-visible buffer, stalling on m_done and aborting after TIMEOUT stalled cycles.
module dct_master
   import dct_pkg::*;
#(
   parameter int MAX_SIZE = MAX_SIZE_DEF,
   parameter int NBITS    = NBITS_DEF,
   parameter int TIMEOUT  = 1024
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        h_wr,
   input  logic [$clog2(MAX_SIZE)-1:0] h_waddr,
   input  logic [NBITS-1:0]            h_wdata,
   input  logic [$clog2(MAX_SIZE)-1:0] h_raddr,
   output logic [NBITS-1:0]            h_rdata,
   input  logic [7:0]                  size,
   input  logic [NBITS-1:0]            qm,
   input  logic                        start,
   output logic                        busy,
   output logic                        finished,
   output logic                        err,
   dct_master_if.master                bus
);

   localparam int AW = $clog2(MAX_SIZE);
   localparam int TW = $clog2(TIMEOUT + 1);

   dct_master_state_t state_q, state_d;
   logic [7:0]        idx_q, idx_d;
   logic [7:0]        size_q, size_d;
   logic [NBITS-1:0]  qm_q, qm_d;
   logic [TW-1:0]     wait_q, wait_d;
   logic              busy_q, busy_d;
   logic              finished_q, finished_d;
   logic              err_q, err_d;

   logic [7:0]        m_address_q, m_address_d;
   logic              m_write_q, m_write_d;
   logic              m_read_q, m_read_d;
   logic [NBITS-1:0]  m_writedata_q, m_writedata_d;

   logic              last_s;
   logic              sample_we_s;
   logic              result_we_s;
   logic [NBITS-1:0]  sample_rdata_s;

   assign last_s      = (idx_q == (size_q - 8'd1));
   // The sample buffer is locked for the whole transaction.
   assign sample_we_s = h_wr && !busy_q;
   assign result_we_s = (state_q == S_READ) && bus.m_done;

   dct_buffer #(.DEPTH(MAX_SIZE), .WIDTH(NBITS)) u_samples (
      .clk     (clk),
      .rst_n   (reset),
      .we_i    (sample_we_s),
      .waddr_i (h_waddr),
      .wdata_i (h_wdata),
      .raddr_i (idx_d[AW-1:0]),
      .rdata_o (sample_rdata_s)
   );

   dct_buffer #(.DEPTH(MAX_SIZE), .WIDTH(NBITS)) u_results (
      .clk     (clk),
      .rst_n   (reset),
      .we_i    (result_we_s),
      .waddr_i (idx_q[AW-1:0]),
      .wdata_i (bus.m_readdata),
      .raddr_i (h_raddr),
      .rdata_o (h_rdata)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      size_d     = size_q;
      qm_d       = qm_q;
      wait_d     = wait_q;
      busy_d     = busy_q;
      finished_d = finished_q;
      err_d      = err_q;
      case (state_q)
         S_IDLE: begin
            if (start && size_ok(size, MAX_SIZE)) begin
               size_d     = size;
               qm_d       = qm;
               idx_d      = 8'd0;
               wait_d     = '0;
               finished_d = 1'b0;
               err_d      = 1'b0;
               busy_d     = 1'b1;
               state_d    = S_SETQ;
            end else if (start) begin
               err_d = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SETQ: state_d = S_SIZE;
         S_SIZE: begin
            idx_d   = 8'd0;
            state_d = S_DATA;
         end
         S_DATA: begin
            if (last_s) begin
               idx_d   = 8'd0;
               wait_d  = '0;
               state_d = S_READ;
            end else begin
               idx_d = idx_q + 8'd1;
            end
         end
         S_READ: begin
            if (bus.m_done) begin
               wait_d = '0;
               if (last_s) begin
                  busy_d     = 1'b0;
                  finished_d = 1'b1;
                  state_d    = S_DONE;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end else if (wait_q == TW'(TIMEOUT - 1)) begin
               busy_d  = 1'b0;
               err_d   = 1'b1;
               state_d = S_FAIL;
            end else begin
               wait_d = wait_q + {{(TW-1){1'b0}}, 1'b1};
            end
         end
         S_DONE: state_d = S_IDLE;
         S_FAIL: state_d = S_IDLE;
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Bus outputs are registered, so they are decoded from the state being entered.
   always_comb begin
      m_write_d     = 1'b0;
      m_read_d      = 1'b0;
      m_address_d   = 8'h00;
      m_writedata_d = '0;
      case (state_d)
         S_SETQ: begin
            m_write_d     = 1'b1;
            m_address_d   = ADDR_SETQ;
            m_writedata_d = qm_d;
         end
         S_SIZE: begin
            m_write_d     = 1'b1;
            m_address_d   = ADDR_START;
            m_writedata_d = NBITS'(size_d);
         end
         S_DATA: begin
            m_write_d     = 1'b1;
            m_address_d   = ADDR_DATA;
            m_writedata_d = sample_rdata_s;
         end
         S_READ: begin
            m_read_d    = 1'b1;
            m_address_d = idx_d;
         end
         default: begin
            m_write_d = 1'b0;
            m_read_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         idx_q         <= 8'd0;
         size_q        <= 8'd0;
         qm_q          <= '0;
         wait_q        <= '0;
         busy_q        <= 1'b0;
         finished_q    <= 1'b0;
         err_q         <= 1'b0;
         m_address_q   <= 8'h00;
         m_write_q     <= 1'b0;
         m_read_q      <= 1'b0;
         m_writedata_q <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         size_q        <= size_d;
         qm_q          <= qm_d;
         wait_q        <= wait_d;
         busy_q        <= busy_d;
         finished_q    <= finished_d;
         err_q         <= err_d;
         m_address_q   <= m_address_d;
         m_write_q     <= m_write_d;
         m_read_q      <= m_read_d;
         m_writedata_q <= m_writedata_d;
      end
   end

   assign busy            = busy_q;
   assign finished        = finished_q;
   assign err             = err_q;
   assign bus.m_address   = m_address_q;
   assign bus.m_write     = m_write_q;
   assign bus.m_read      = m_read_q;
   assign bus.m_writedata = m_writedata_q;

endmodule

// File: tb/tb_dct_master.sv
// Directed, table-driven bench for dct_master against a stub responder that returns 0x1000+address.
module tb_dct_master;
   import dct_pkg::*;

   localparam int MAX_SIZE = 32;
   localparam int NBITS    = 16;
   localparam int TIMEOUT  = 8;
   localparam int WIN      = 80;

   logic             clk = 1'b0;
   logic             reset;
   logic             h_wr;
   logic [4:0]       h_waddr;
   logic [15:0]      h_wdata;
   logic [4:0]       h_raddr;
   logic [15:0]      h_rdata;
   logic [7:0]       size;
   logic [15:0]      qm;
   logic             start;
   logic             busy;
   logic             finished;
   logic             err;

   int checks   = 0;
   int failures = 0;
   int mode     = 0;
   int stall_cnt = 0;

   always #5 clk = ~clk;

   dct_master_if #(.NBITS(NBITS)) bus ();

   dct_master #(.MAX_SIZE(MAX_SIZE), .NBITS(NBITS), .TIMEOUT(TIMEOUT)) dut (
      .clk      (clk),
      .reset    (reset),
      .h_wr     (h_wr),
      .h_waddr  (h_waddr),
      .h_wdata  (h_wdata),
      .h_raddr  (h_raddr),
      .h_rdata  (h_rdata),
      .size     (size),
      .qm       (qm),
      .start    (start),
      .busy     (busy),
      .finished (finished),
      .err      (err),
      .bus      (bus)
   );

   // Stub responder: mode 0 never stalls, mode 1 stalls 3 cycles per read, mode 2 never answers.
   always_comb begin
      bus.m_readdata = 16'h1000 + {8'h00, bus.m_address};
      case (mode)
         0:       bus.m_done = 1'b1;
         1:       bus.m_done = (stall_cnt == 3);
         default: bus.m_done = 1'b0;
      endcase
   end

   always @(posedge clk) begin
      if (bus.m_read && !bus.m_done) stall_cnt <= stall_cnt + 1;
      else                           stall_cnt <= 0;
   end

   typedef struct {
      logic [7:0]  size;
      logic [15:0] qm;
      int          mode;
      bit          disturb;
      int          exp_end;
      bit          exp_err;
      bit          exp_fin;
      int          exp_nwr;
      int          exp_nrd;
   } vec_t;

   vec_t vecs [11];

   logic [7:0]  wr_addr [$];
   logic [15:0] wr_data [$];
   logic [7:0]  rd_addr [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic load_samples();
      for (int i = 0; i < MAX_SIZE; i++) begin
         @(posedge clk); #1;
         h_wr    = 1'b1;
         h_waddr = 5'(i);
         h_wdata = 16'(i + 1);
      end
      @(posedge clk); #1;
      h_wr = 1'b0;
   endtask

   task automatic run(input vec_t v);
      int end_c, busy_c, both_c;
      logic err_at, fin_at;
      logic [7:0]  ea;
      logic [15:0] ed;
      wr_addr.delete(); wr_data.delete(); rd_addr.delete();
      end_c = -1; busy_c = 0; both_c = 0; err_at = 1'b0; fin_at = 1'b0;
      @(posedge clk); #1;
      size = v.size; qm = v.qm; mode = v.mode; start = 1'b1;
      for (int c = 0; c < WIN; c++) begin
         @(negedge clk);
         if (bus.m_write) begin
            wr_addr.push_back(bus.m_address);
            wr_data.push_back(bus.m_writedata);
         end
         if (bus.m_read) rd_addr.push_back(bus.m_address);
         if (bus.m_write && bus.m_read) both_c++;
         if (busy) busy_c++;
         if (c >= 1 && !busy && end_c < 0) begin
            end_c  = c;
            err_at = err;
            fin_at = finished;
         end
         if (c == 0) begin
            @(posedge clk); #1;
            start = 1'b0;
         end else if (c == 3 && v.disturb) begin
            start = 1'b1; size = 8'd2; h_wr = 1'b1; h_waddr = 5'd0; h_wdata = 16'hBEEF;
         end else if (c == 4 && v.disturb) begin
            start = 1'b0; h_wr = 1'b0;
         end
      end
      chk("end_cycle",   end_c,          v.exp_end);
      chk("err",         err_at,         v.exp_err);
      chk("finished",    fin_at,         v.exp_fin);
      chk("n_writes",    wr_addr.size(), v.exp_nwr);
      chk("n_reads",     rd_addr.size(), v.exp_nrd);
      chk("busy_cycles", busy_c,         v.exp_end - 1);
      chk("rw_overlap",  both_c,         0);
      for (int k = 0; k < wr_addr.size(); k++) begin
         if (k == 0)      begin ea = 8'h2; ed = v.qm;            end
         else if (k == 1) begin ea = 8'h0; ed = {8'h00, v.size}; end
         else             begin ea = 8'h1; ed = 16'(k - 1);      end
         chk($sformatf("wr_addr[%0d]", k), wr_addr[k], ea);
         chk($sformatf("wr_data[%0d]", k), wr_data[k], ed);
      end
      for (int k = 0; k < rd_addr.size(); k++) begin
         ea = (v.mode == 1) ? 8'(k / 4) : (v.mode == 0) ? 8'(k) : 8'h0;
         chk($sformatf("rd_addr[%0d]", k), rd_addr[k], ea);
      end
      if (!v.exp_err) begin
         for (int i = 0; i < int'(v.size); i++) begin
            h_raddr = 5'(i);
            #1;
            chk($sformatf("result[%0d]", i), h_rdata, 16'h1000 + 16'(i));
         end
      end
   endtask

   initial begin
      //          size    qm        mode dist end err fin nwr nrd
      vecs[0]  = '{8'd4,   16'h0001, 0, 1'b0, 11, 1'b0, 1'b1, 6,  4};
      vecs[1]  = '{8'd4,   16'h0001, 1, 1'b0, 23, 1'b0, 1'b1, 6,  16};
      vecs[2]  = '{8'd1,   16'h0001, 0, 1'b0, 1,  1'b1, 1'b1, 0,  0};
      vecs[3]  = '{8'd33,  16'h0001, 0, 1'b0, 1,  1'b1, 1'b1, 0,  0};
      vecs[4]  = '{8'd0,   16'h0001, 0, 1'b0, 1,  1'b1, 1'b1, 0,  0};
      vecs[5]  = '{8'd2,   16'h0007, 0, 1'b0, 7,  1'b0, 1'b1, 4,  2};
      vecs[6]  = '{8'd32,  16'h00F0, 0, 1'b0, 67, 1'b0, 1'b1, 34, 32};
      vecs[7]  = '{8'd4,   16'h0003, 2, 1'b0, 15, 1'b1, 1'b0, 6,  8};
      vecs[8]  = '{8'd255, 16'h0001, 0, 1'b0, 1,  1'b1, 1'b0, 0,  0};
      vecs[9]  = '{8'd4,   16'h0001, 1, 1'b1, 23, 1'b0, 1'b1, 6,  16};
      vecs[10] = '{8'd2,   16'h0007, 0, 1'b0, 7,  1'b0, 1'b1, 4,  2};

      reset = 1'b0; h_wr = 1'b0; h_waddr = 5'd0; h_wdata = 16'h0; h_raddr = 5'd0;
      size = 8'd0; qm = 16'h0; start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_m_write",  bus.m_write,   1'b0);
      chk("rst_m_read",   bus.m_read,    1'b0);
      chk("rst_m_addr",   bus.m_address, 8'h00);
      chk("rst_m_wdata",  bus.m_writedata, 16'h0000);
      chk("rst_busy",     busy,          1'b0);
      chk("rst_finished", finished,      1'b0);
      chk("rst_err",      err,           1'b0);
      chk("rst_result",   h_rdata,       16'h0000);
      @(posedge clk); #1;
      reset = 1'b1;
      load_samples();

      for (int n = 0; n < 11; n++) begin
         run(vecs[n]);
      end

      // Reset in the middle of DATA (third sample write, cycle 5).
      mode = 0;
      @(posedge clk); #1;
      size = 8'd4; qm = 16'h0001; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("mid_data_write", bus.m_write,     1'b1);
      chk("mid_data_addr",  bus.m_address,   8'h01);
      chk("mid_data_wdata", bus.m_writedata, 16'h0003);
      reset = 1'b0;
      h_raddr = 5'd1;
      #1;
      chk("arst_m_write", bus.m_write, 1'b0);
      chk("arst_m_read",  bus.m_read,  1'b0);
      chk("arst_busy",    busy,        1'b0);
      chk("arst_result",  h_rdata,     16'h0000);
      @(posedge clk); #1;
      reset = 1'b1;
      load_samples();
      run(vecs[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
